// File: rtl/fp_alu_issue_stage.sv
// Issue stage in front of the combinational FP ALU: buffers commands in a
// small FIFO, presents one command at a time to the ALU, holds the operands
// for a programmable settle time, then captures the result and flags into a
// valid/ready output register and accumulates sticky exception status.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | nothing in flight; pops the FIFO head as soon as one exists
// SETTLE | ALU inputs held stable, settle counter running down to 0
// HOLD   | result registered and offered until the consumer takes it
module fp_alu_issue_stage #(
  parameter int DEPTH         = 4,
  parameter int TAG_W         = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [31:0]      cmd_a,
  input  logic [31:0]      cmd_b,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic [31:0]      alu_a_operand,
  output logic [31:0]      alu_b_operand,
  output logic [3:0]       alu_operation,
  input  logic [31:0]      alu_result,
  input  logic             alu_exception,
  input  logic             alu_overflow,
  input  logic             alu_underflow,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_data,
  output logic [TAG_W-1:0] res_tag,
  output logic [3:0]       res_flags,
  output logic [3:0]       sticky_status,
  input  logic             sticky_clear,
  output logic             busy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);
  localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_HOLD
  } state_t;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [3:0]       op;
    logic [31:0]      a;
    logic [31:0]      b;
  } cmd_t;

  // FIFO storage and pointers (extra MSB distinguishes full from empty)
  cmd_t           fifo_q [DEPTH];
  cmd_t           fifo_d [DEPTH];
  logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
  logic           fifo_empty;
  logic           fifo_full;
  logic           push;
  logic           pop;
  cmd_t           head;
  logic           head_legal;

  // Sequencer state
  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  logic [3:0]       op_q, op_d;
  logic             ill_q, ill_d;
  logic [TAG_W-1:0] cur_tag_q, cur_tag_d;
  logic             capture;

  // Result and status registers
  logic             res_valid_q, res_valid_d;
  logic [31:0]      res_data_q, res_data_d;
  logic [TAG_W-1:0] res_tag_q, res_tag_d;
  logic [3:0]       res_flags_q, res_flags_d;
  logic [3:0]       sticky_q, sticky_d;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  // Ready depends only on registered pointers, so a full FIFO never takes a
  // push even on an edge where it also pops.
  assign cmd_ready  = !fifo_full;
  assign push       = cmd_valid && !fifo_full;
  assign head       = fifo_q[rd_ptr_q[PTR_W-1:0]];
  assign head_legal = (head.op != 4'd0) && (head.op <= 4'd12);

  // FIFO next-state: write at the tail on push, advance the head on pop
  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      fifo_d[wr_ptr_q[PTR_W-1:0]] = '{tag: cmd_tag, op: cmd_op, a: cmd_a, b: cmd_b};
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  // FIFO registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      fifo_q   <= fifo_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Sequencer next-state, ALU drive, result capture and sticky accumulation
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    ill_d       = ill_q;
    cur_tag_d   = cur_tag_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_tag_d   = res_tag_q;
    res_flags_d = res_flags_q;
    pop         = 1'b0;
    capture     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop = 1'b1;
        end
      end
      S_SETTLE: begin
        if (cnt_q == 4'd0) begin
          capture     = 1'b1;
          state_d     = S_HOLD;
          op_d        = 4'd0;
          res_valid_d = 1'b1;
          res_tag_d   = cur_tag_q;
          // An illegal opcode never drove the ALU, so its bus is not sampled.
          if (ill_q) begin
            res_data_d  = 32'd0;
            res_flags_d = 4'b1000;
          end else begin
            res_data_d  = alu_result;
            res_flags_d = {1'b0, alu_underflow, alu_overflow, alu_exception};
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_HOLD: begin
        if (res_valid_q && res_ready) begin
          res_valid_d = 1'b0;
          if (!fifo_empty) begin
            pop = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Launching a command is identical from IDLE and from HOLD.
    if (pop) begin
      state_d   = S_SETTLE;
      a_d       = head.a;
      b_d       = head.b;
      ill_d     = !head_legal;
      op_d      = head_legal ? head.op : 4'd0;
      cur_tag_d = head.tag;
      cnt_d     = CNT_LOAD;
    end

    // Clear wins over a simultaneous capture; those flags remain in res_flags.
    if (sticky_clear) begin
      sticky_d = 4'd0;
    end else if (capture) begin
      sticky_d = sticky_q | res_flags_d;
    end else begin
      sticky_d = sticky_q;
    end
  end

  // Sequencer, ALU input and result registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      a_q         <= 32'd0;
      b_q         <= 32'd0;
      op_q        <= 4'd0;
      ill_q       <= 1'b0;
      cur_tag_q   <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= 32'd0;
      res_tag_q   <= '0;
      res_flags_q <= 4'd0;
      sticky_q    <= 4'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      ill_q       <= ill_d;
      cur_tag_q   <= cur_tag_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_tag_q   <= res_tag_d;
      res_flags_q <= res_flags_d;
      sticky_q    <= sticky_d;
    end
  end

  assign alu_a_operand = a_q;
  assign alu_b_operand = b_q;
  assign alu_operation = op_q;
  assign res_valid     = res_valid_q;
  assign res_data      = res_data_q;
  assign res_tag       = res_tag_q;
  assign res_flags     = res_flags_q;
  assign sticky_status = sticky_q;
  assign busy          = !fifo_empty || (state_q != S_IDLE);

endmodule

// File: tb/tb_fp_alu_issue_stage.sv
// Directed bench for fp_alu_issue_stage with a behavioural ALU that only
// produces a valid answer once its inputs have been stable for SETTLE cycles.
module tb_fp_alu_issue_stage;

  localparam int DEPTH  = 4;
  localparam int TAG_W  = 4;
  localparam int SETTLE = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [3:0]       cmd_op = 4'd0;
  logic [31:0]      cmd_a = 32'd0;
  logic [31:0]      cmd_b = 32'd0;
  logic [TAG_W-1:0] cmd_tag = '0;
  logic [31:0]      alu_a_operand;
  logic [31:0]      alu_b_operand;
  logic [3:0]       alu_operation;
  logic [31:0]      alu_result;
  logic             alu_exception;
  logic             alu_overflow;
  logic             alu_underflow;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic [31:0]      res_data;
  logic [TAG_W-1:0] res_tag;
  logic [3:0]       res_flags;
  logic [3:0]       sticky_status;
  logic             sticky_clear = 1'b0;
  logic             busy;

  fp_alu_issue_stage #(
    .DEPTH(DEPTH), .TAG_W(TAG_W), .SETTLE_CYCLES(SETTLE)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag),
    .alu_a_operand(alu_a_operand), .alu_b_operand(alu_b_operand),
    .alu_operation(alu_operation), .alu_result(alu_result),
    .alu_exception(alu_exception), .alu_overflow(alu_overflow),
    .alu_underflow(alu_underflow),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_tag(res_tag), .res_flags(res_flags),
    .sticky_status(sticky_status), .sticky_clear(sticky_clear), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0]      data;
    logic [TAG_W-1:0] tag;
    logic [3:0]       flags;
  } exp_t;

  exp_t        sb[$];
  int unsigned hs_cyc[$];
  int unsigned cyc = 0;
  int          vec_cnt = 0;
  int          err_cnt = 0;
  logic [3:0]  exp_sticky = 4'd0;
  bit          watch_op = 1'b0;
  int          age = 0;
  logic [67:0] prev_in = '0;
  exp_t        mon_e;

  function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op == 4'd10 && a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
    if (op == 4'd1  && a == 32'h40000000 && b == 32'h40400000) return 32'h40C00000;
    if (op == 4'd2  && a == 32'h40C00000 && b == 32'h40000000) return 32'h40400000;
    if (op == 4'd1  && a == 32'h7F000000 && b == 32'h7F000000) return 32'h7F800000;
    return (a ^ {b[15:0], b[31:16]}) + {28'h0, op};
  endfunction

  // returns {underflow, overflow, exception}
  function automatic logic [2:0] flag_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [2:0] f;
    f[2] = (op == 4'd2) && (b == 32'h7F000000);
    f[1] = (op == 4'd1) && (a == 32'h7F000000) && (b == 32'h7F000000);
    f[0] = (op == 4'd9) && a[31];
    return f;
  endfunction

  // ALU inputs stability age, counted in negedges since the last change
  always @(negedge clk) begin
    if ({alu_operation, alu_a_operand, alu_b_operand} === prev_in) age <= age + 1;
    else age <= 1;
    prev_in <= {alu_operation, alu_a_operand, alu_b_operand};
  end

  // Behavioural ALU: garbage when idle or not yet settled
  always_comb begin
    alu_result = 32'hDEADBEEF;
    {alu_underflow, alu_overflow, alu_exception} = 3'b111;
    if (alu_operation != 4'd0 && age >= SETTLE) begin
      alu_result = alu_fn(alu_operation, alu_a_operand, alu_b_operand);
      {alu_underflow, alu_overflow, alu_exception} = flag_fn(alu_operation, alu_a_operand, alu_b_operand);
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cmd(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] tag);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    cmd_tag   = tag;
  endtask

  task automatic wait_accept(input int bound);
    bit   r;
    bit   done;
    bit   legal;
    exp_t e;
    done = 1'b0;
    for (int i = 0; i < bound && !done; i++) begin
      @(negedge clk);
      r = cmd_ready;
      @(posedge clk);
      #1;
      if (r) done = 1'b1;
    end
    check("cmd_accept", 32'(done), 32'd1);
    if (done) begin
      legal   = (cmd_op >= 4'd1) && (cmd_op <= 4'd12);
      e.data  = legal ? alu_fn(cmd_op, cmd_a, cmd_b) : 32'd0;
      e.flags = legal ? {1'b0, flag_fn(cmd_op, cmd_a, cmd_b)} : 4'b1000;
      e.tag   = cmd_tag;
      sb.push_back(e);
      exp_sticky = exp_sticky | e.flags;
    end
    cmd_valid = 1'b0;
  endtask

  task automatic push(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] tag);
    drive_cmd(op, a, b, tag);
    wait_accept(50);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (!busy && sb.size() == 0) ok = 1'b1;
    end
    check("drain", 32'(ok), 32'd1);
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every accepted result must match the oldest pending command
  always @(negedge clk) begin
    if (!reset && res_valid && res_ready) begin
      hs_cyc.push_back(cyc);
      check("result_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        check("res_data", res_data, mon_e.data);
        check("res_tag", 32'(res_tag), 32'(mon_e.tag));
        check("res_flags", 32'(res_flags), 32'(mon_e.flags));
      end
    end
    if (watch_op) check("alu_op_illegal", 32'(alu_operation), 32'd0);
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    // Reset values
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_alu_op", 32'(alu_operation), 32'd0);
    check("rst_alu_a", alu_a_operand, 32'd0);
    check("rst_sticky", 32'(sticky_status), 32'd0);
    reset = 1'b0;
    tick();
    check("idle_res_data", res_data, 32'd0);
    check("idle_busy", 32'(busy), 32'd0);

    // 1: single add, latency and operand hold
    push(4'd10, 32'h3F800000, 32'h40000000, 4'd3);
    check("t1_busy_after_accept", 32'(busy), 32'd1);
    tick();
    check("t1_valid_e1", 32'(res_valid), 32'd0);
    check("t1_alu_op", 32'(alu_operation), 32'd10);
    check("t1_alu_a", alu_a_operand, 32'h3F800000);
    check("t1_alu_b", alu_b_operand, 32'h40000000);
    tick();
    check("t1_valid_e2", 32'(res_valid), 32'd0);
    tick();
    check("t1_valid_e3", 32'(res_valid), 32'd1);
    check("t1_res_data", res_data, 32'h40400000);
    check("t1_res_tag", 32'(res_tag), 32'd3);
    check("t1_res_flags", 32'(res_flags), 32'd0);
    check("t1_alu_op_cleared", 32'(alu_operation), 32'd0);
    check("t1_alu_a_kept", alu_a_operand, 32'h3F800000);
    res_ready = 1'b1;
    tick();
    check("t1_valid_consumed", 32'(res_valid), 32'd0);
    wait_idle();

    // 2: back-to-back mul/div, in order, SETTLE+1 cycles apart
    hs_cyc.delete();
    push(4'd1, 32'h40000000, 32'h40400000, 4'd1);
    push(4'd2, 32'h40C00000, 32'h40000000, 4'd2);
    wait_idle();
    check("t2_results", 32'(hs_cyc.size()), 32'd2);
    if (hs_cyc.size() == 2) check("t2_spacing", hs_cyc[1] - hs_cyc[0], 32'(SETTLE + 1));

    // 3: overflow reaches sticky, then clear
    push(4'd1, 32'h7F000000, 32'h7F000000, 4'd5);
    wait_idle();
    check("t3_sticky", 32'(sticky_status), 32'(exp_sticky));
    check("t3_sticky_ovf", 32'(sticky_status[1]), 32'd1);
    sticky_clear = 1'b1;
    tick();
    sticky_clear = 1'b0;
    exp_sticky = 4'd0;
    check("t3_sticky_cleared", 32'(sticky_status), 32'd0);

    // 4: illegal opcodes never drive the ALU
    watch_op = 1'b1;
    push(4'd0,  32'h11111111, 32'h22222222, 4'd6);
    push(4'd13, 32'h33333333, 32'h44444444, 4'd7);
    wait_idle();
    watch_op = 1'b0;
    check("t4_sticky", 32'(sticky_status), 32'(exp_sticky));

    // 5: backpressure fills the FIFO, then drains in order
    res_ready = 1'b0;
    push(4'd3, 32'h40000000, 32'h3F800000, 4'd8);
    push(4'd2, 32'h3F800000, 32'h7F000000, 4'd9);
    push(4'd9, 32'hC0000000, 32'h00000000, 4'd10);
    push(4'd6, 32'h12345678, 32'h0F0F0F0F, 4'd11);
    push(4'd8, 32'h00000010, 32'h00000001, 4'd12);
    drive_cmd(4'd12, 32'h00000005, 32'h00000000, 4'd13);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t5_cmd_ready_full", 32'(cmd_ready), 32'd0);
      check("t5_res_valid_hold", 32'(res_valid), 32'd1);
      check("t5_res_data_hold", res_data, sb[0].data);
      check("t5_res_tag_hold", 32'(res_tag), 32'(sb[0].tag));
    end
    res_ready = 1'b1;
    wait_accept(50);
    wait_idle();
    check("t5_cmd_ready", 32'(cmd_ready), 32'd1);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_sticky", 32'(sticky_status), 32'(exp_sticky));

    // 6: reset during SETTLE with two commands queued
    push(4'd1, 32'h7F000000, 32'h7F000000, 4'd1);
    wait_idle();
    push(4'd10, 32'h3F800000, 32'h40000000, 4'd2);
    push(4'd3, 32'h40000000, 32'h3F800000, 4'd3);
    push(4'd4, 32'h0000FFFF, 32'hFFFF0000, 4'd4);
    #1;
    reset = 1'b1;
    #1;
    check("t6_res_valid", 32'(res_valid), 32'd0);
    check("t6_res_data", res_data, 32'd0);
    check("t6_res_tag", 32'(res_tag), 32'd0);
    check("t6_res_flags", 32'(res_flags), 32'd0);
    check("t6_sticky", 32'(sticky_status), 32'd0);
    check("t6_alu_a", alu_a_operand, 32'd0);
    check("t6_alu_b", alu_b_operand, 32'd0);
    check("t6_alu_op", 32'(alu_operation), 32'd0);
    check("t6_cmd_ready", 32'(cmd_ready), 32'd1);
    check("t6_busy", 32'(busy), 32'd0);
    sb.delete();
    exp_sticky = 4'd0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    hs_cyc.delete();
    repeat (20) tick();
    check("t6_no_stale_result", 32'(hs_cyc.size()), 32'd0);
    check("t6_res_valid_after", 32'(res_valid), 32'd0);
    check("t6_busy_after", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
